// File: rtl/apb2axi_tag_directory_if.sv
// Handshake bundle between the APB register file / completion queue (master)
// and the tag directory (slave).
//   alloc_* : new descriptor offer and the tag assigned to it
//   pop_*   : in-order issue of descriptors to the AXI manager FIFO
//   cpl_*   : completions returning from the completion queue
//   cns_*   : APB consuming a finished entry
interface apb2axi_tag_directory_if #(
  parameter int TAG_W  = 3,
  parameter int ADDR_W = 32
);
  logic              alloc_vld;
  logic [ADDR_W-1:0] alloc_addr;
  logic [7:0]        alloc_len;
  logic [2:0]        alloc_size;
  logic              alloc_is_write;
  logic              alloc_rdy;
  logic [TAG_W-1:0]  alloc_tag;

  logic              pop_vld;
  logic [TAG_W-1:0]  pop_tag;
  logic [ADDR_W-1:0] pop_addr;
  logic [7:0]        pop_len;
  logic [2:0]        pop_size;
  logic              pop_is_write;
  logic              pop_rdy;

  logic              cpl_vld;
  logic [TAG_W-1:0]  cpl_tag;
  logic [1:0]        cpl_resp;
  logic [7:0]        cpl_num_beats;
  logic              cpl_error;
  logic              cpl_rdy;

  logic              cns_vld;
  logic [TAG_W-1:0]  cns_tag;

  modport slave (
    input  alloc_vld, alloc_addr, alloc_len, alloc_size, alloc_is_write,
    output alloc_rdy, alloc_tag,
    output pop_vld, pop_tag, pop_addr, pop_len, pop_size, pop_is_write,
    input  pop_rdy,
    input  cpl_vld, cpl_tag, cpl_resp, cpl_num_beats, cpl_error,
    output cpl_rdy,
    input  cns_vld, cns_tag
  );

  modport master (
    output alloc_vld, alloc_addr, alloc_len, alloc_size, alloc_is_write,
    input  alloc_rdy, alloc_tag,
    input  pop_vld, pop_tag, pop_addr, pop_len, pop_size, pop_is_write,
    output pop_rdy,
    output cpl_vld, cpl_tag, cpl_resp, cpl_num_beats, cpl_error,
    input  cpl_rdy,
    output cns_vld, cns_tag
  );
endinterface

// File: rtl/apb2axi_tag_directory.sv
// Transaction directory for the APB-to-AXI gateway. Holds up to N_ENTRIES
// descriptors indexed by tag and issues them in allocation order through an
// age queue, with separate read/write outstanding limits and a per-entry
// PENDING timeout.
// Ports:
//   pclk, preset     : clock, async active-high reset
//   dir (slave)      : alloc / pop / completion / consume handshakes
//   stat_tag, stat_* : combinational status readout of one entry
//   cnt_*            : EMPTY and PENDING read/write counts
//   evt_*            : one-cycle pulses for stale completions / bad consumes
//
// Entry states:
//   state   | meaning
//   EMPTY   | free, fields cleared
//   ALLOC   | descriptor stored, waiting in age queue
//   PENDING | issued to manager FIFO, timeout counter running
//   DONE    | completed OK, waiting for consume
//   ERROR   | completed with error flag or resp[1], waiting for consume
//   TIMEOUT | no completion within TIMEOUT_CYC, waiting for consume
module apb2axi_tag_directory #(
  parameter int N_ENTRIES   = 8,
  parameter int TAG_W       = $clog2(N_ENTRIES),
  parameter int ADDR_W      = 32,
  parameter int MAX_RD_OUT  = 4,
  parameter int MAX_WR_OUT  = 4,
  parameter int TIMEOUT_CYC = 1024,
  parameter int TO_W        = 16
) (
  input  logic                pclk,
  input  logic                preset,
  apb2axi_tag_directory_if.slave dir,
  input  logic [TAG_W-1:0]    stat_tag,
  output logic [2:0]          stat_state,
  output logic [ADDR_W-1:0]   stat_addr,
  output logic [7:0]          stat_len,
  output logic [2:0]          stat_size,
  output logic                stat_is_write,
  output logic [1:0]          stat_resp,
  output logic [7:0]          stat_num_beats,
  output logic [TAG_W:0]      cnt_free,
  output logic [TAG_W:0]      cnt_rd_pend,
  output logic [TAG_W:0]      cnt_wr_pend,
  output logic                evt_stale_cpl,
  output logic                evt_bad_cns
);

  typedef enum logic [2:0] {
    ST_EMPTY = 3'd0,
    ST_ALLOC = 3'd1,
    ST_PEND  = 3'd2,
    ST_DONE  = 3'd3,
    ST_ERR   = 3'd4,
    ST_TMO   = 3'd5
  } ent_state_e;

  localparam logic [TAG_W:0]  ONE     = (TAG_W+1)'(1);
  localparam logic [TAG_W:0]  RD_LIM  = (TAG_W+1)'(MAX_RD_OUT);
  localparam logic [TAG_W:0]  WR_LIM  = (TAG_W+1)'(MAX_WR_OUT);
  localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT_CYC - 1);

  ent_state_e        state_q [N_ENTRIES], state_d [N_ENTRIES];
  logic [ADDR_W-1:0] addr_q  [N_ENTRIES], addr_d  [N_ENTRIES];
  logic [7:0]        len_q   [N_ENTRIES], len_d   [N_ENTRIES];
  logic [2:0]        size_q  [N_ENTRIES], size_d  [N_ENTRIES];
  logic              wr_q    [N_ENTRIES], wr_d    [N_ENTRIES];
  logic [1:0]        resp_q  [N_ENTRIES], resp_d  [N_ENTRIES];
  logic [7:0]        beats_q [N_ENTRIES], beats_d [N_ENTRIES];
  logic [TO_W-1:0]   to_q    [N_ENTRIES], to_d    [N_ENTRIES];
  logic [TAG_W-1:0]  aq_q    [N_ENTRIES], aq_d    [N_ENTRIES];
  logic [TAG_W:0]    wp_q, wp_d, rp_q, rp_d;
  logic              stale_q, stale_d, bad_q, bad_d;

  logic [TAG_W-1:0]  free_tag, head_tag;
  logic [TAG_W:0]    free_c, rd_c, wr_c;
  logic              q_empty, head_ok, alloc_fire, pop_fire, cpl_hit, cns_hit;

  // Lowest EMPTY tag and population counts, all from registered state.
  always_comb begin
    free_tag = '0;
    free_c   = '0;
    rd_c     = '0;
    wr_c     = '0;
    for (int i = N_ENTRIES - 1; i >= 0; i--) begin
      if (state_q[i] == ST_EMPTY) begin
        free_tag = TAG_W'(i);
        free_c   = free_c + ONE;
      end
      if (state_q[i] == ST_PEND) begin
        if (wr_q[i]) wr_c = wr_c + ONE;
        else         rd_c = rd_c + ONE;
      end
    end
  end

  // Head-of-line blocking: a head over its type's limit stalls everything behind it.
  assign head_tag = aq_q[rp_q[TAG_W-1:0]];
  assign q_empty  = (wp_q == rp_q);
  assign head_ok  = wr_q[head_tag] ? (wr_c < WR_LIM) : (rd_c < RD_LIM);

  assign dir.alloc_rdy    = (free_c != '0);
  assign dir.alloc_tag    = free_tag;
  assign dir.pop_vld      = !q_empty && head_ok;
  assign dir.pop_tag      = head_tag;
  assign dir.pop_addr     = addr_q[head_tag];
  assign dir.pop_len      = len_q[head_tag];
  assign dir.pop_size     = size_q[head_tag];
  assign dir.pop_is_write = wr_q[head_tag];
  assign dir.cpl_rdy      = 1'b1;

  assign stat_state     = state_q[stat_tag];
  assign stat_addr      = addr_q[stat_tag];
  assign stat_len       = len_q[stat_tag];
  assign stat_size      = size_q[stat_tag];
  assign stat_is_write  = wr_q[stat_tag];
  assign stat_resp      = resp_q[stat_tag];
  assign stat_num_beats = beats_q[stat_tag];
  assign cnt_free       = free_c;
  assign cnt_rd_pend    = rd_c;
  assign cnt_wr_pend    = wr_c;
  assign evt_stale_cpl  = stale_q;
  assign evt_bad_cns    = bad_q;

  assign alloc_fire = dir.alloc_vld && dir.alloc_rdy;
  assign pop_fire   = dir.pop_vld && dir.pop_rdy;
  assign cpl_hit    = dir.cpl_vld && (state_q[dir.cpl_tag] == ST_PEND);
  assign cns_hit    = dir.cns_vld && (state_q[dir.cns_tag] inside {ST_DONE, ST_ERR, ST_TMO});

  // Alloc, pop, completion and consume always address distinct entries
  // (EMPTY, ALLOC head, PENDING, finished), so their updates never collide.
  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    len_d   = len_q;
    size_d  = size_q;
    wr_d    = wr_q;
    resp_d  = resp_q;
    beats_d = beats_q;
    to_d    = to_q;
    aq_d    = aq_q;
    wp_d    = wp_q;
    rp_d    = rp_q;

    for (int i = 0; i < N_ENTRIES; i++) begin
      if (state_q[i] == ST_PEND) begin
        to_d[i] = to_q[i] + TO_W'(1);
        // A completion landing on the expiry cycle takes precedence.
        if ((TIMEOUT_CYC > 0) && (to_q[i] == TO_LAST) &&
            !(cpl_hit && (dir.cpl_tag == TAG_W'(i)))) begin
          state_d[i] = ST_TMO;
          resp_d[i]  = 2'b10;
        end
      end
    end

    if (alloc_fire) begin
      state_d[free_tag]       = ST_ALLOC;
      addr_d[free_tag]        = dir.alloc_addr;
      len_d[free_tag]         = dir.alloc_len;
      size_d[free_tag]        = dir.alloc_size;
      wr_d[free_tag]          = dir.alloc_is_write;
      resp_d[free_tag]        = '0;
      beats_d[free_tag]       = '0;
      aq_d[wp_q[TAG_W-1:0]]   = free_tag;
      wp_d                    = wp_q + ONE;
    end

    if (pop_fire) begin
      state_d[head_tag] = ST_PEND;
      to_d[head_tag]    = '0;
      rp_d              = rp_q + ONE;
    end

    if (cpl_hit) begin
      resp_d[dir.cpl_tag]  = dir.cpl_resp;
      beats_d[dir.cpl_tag] = dir.cpl_num_beats;
      state_d[dir.cpl_tag] = (dir.cpl_error || dir.cpl_resp[1]) ? ST_ERR : ST_DONE;
    end

    if (cns_hit) begin
      state_d[dir.cns_tag] = ST_EMPTY;
      addr_d[dir.cns_tag]  = '0;
      len_d[dir.cns_tag]   = '0;
      size_d[dir.cns_tag]  = '0;
      wr_d[dir.cns_tag]    = 1'b0;
      resp_d[dir.cns_tag]  = '0;
      beats_d[dir.cns_tag] = '0;
      to_d[dir.cns_tag]    = '0;
    end

    stale_d = dir.cpl_vld && !cpl_hit;
    bad_d   = dir.cns_vld && !cns_hit;
  end

  always_ff @(posedge pclk or posedge preset) begin
    if (preset) begin
      for (int i = 0; i < N_ENTRIES; i++) begin
        state_q[i] <= ST_EMPTY;
        addr_q[i]  <= '0;
        len_q[i]   <= '0;
        size_q[i]  <= '0;
        wr_q[i]    <= 1'b0;
        resp_q[i]  <= '0;
        beats_q[i] <= '0;
        to_q[i]    <= '0;
        aq_q[i]    <= '0;
      end
      wp_q    <= '0;
      rp_q    <= '0;
      stale_q <= 1'b0;
      bad_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      len_q   <= len_d;
      size_q  <= size_d;
      wr_q    <= wr_d;
      resp_q  <= resp_d;
      beats_q <= beats_d;
      to_q    <= to_d;
      aq_q    <= aq_d;
      wp_q    <= wp_d;
      rp_q    <= rp_d;
      stale_q <= stale_d;
      bad_q   <= bad_d;
    end
  end

endmodule

// File: tb/tb_apb2axi_tag_directory.sv
module tb_apb2axi_tag_directory;
  localparam int N  = 4;
  localparam int TW = 2;
  localparam int AW = 32;

  logic pclk = 1'b0;
  logic preset = 1'b1;
  always #5 pclk = ~pclk;

  apb2axi_tag_directory_if #(.TAG_W(TW), .ADDR_W(AW)) dir ();

  logic [TW-1:0] stat_tag;
  logic [2:0]    stat_state;
  logic [AW-1:0] stat_addr;
  logic [7:0]    stat_len;
  logic [2:0]    stat_size;
  logic          stat_is_write;
  logic [1:0]    stat_resp;
  logic [7:0]    stat_num_beats;
  logic [TW:0]   cnt_free, cnt_rd_pend, cnt_wr_pend;
  logic          evt_stale_cpl, evt_bad_cns;

  apb2axi_tag_directory #(
    .N_ENTRIES(N), .TAG_W(TW), .ADDR_W(AW), .MAX_RD_OUT(2), .MAX_WR_OUT(4),
    .TIMEOUT_CYC(16), .TO_W(8)
  ) dut (
    .pclk(pclk), .preset(preset), .dir(dir),
    .stat_tag(stat_tag), .stat_state(stat_state), .stat_addr(stat_addr),
    .stat_len(stat_len), .stat_size(stat_size), .stat_is_write(stat_is_write),
    .stat_resp(stat_resp), .stat_num_beats(stat_num_beats),
    .cnt_free(cnt_free), .cnt_rd_pend(cnt_rd_pend), .cnt_wr_pend(cnt_wr_pend),
    .evt_stale_cpl(evt_stale_cpl), .evt_bad_cns(evt_bad_cns)
  );

  typedef struct {
    logic [TW-1:0] tag;
    logic [AW-1:0] addr;
    logic          wr;
  } pop_exp_t;

  pop_exp_t exp_q[$];
  int checks = 0;
  int failures = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Pop monitor: every handshake the DUT completes must match the scoreboard head.
  always @(negedge pclk) begin
    if (!preset && dir.pop_vld === 1'b1 && dir.pop_rdy === 1'b1) begin
      if (exp_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL pop_unexpected: got tag %0d expected no pop at %0t", dir.pop_tag, $time);
      end else begin
        pop_exp_t e;
        e = exp_q.pop_front();
        chk("pop_tag", 32'(dir.pop_tag), 32'(e.tag));
        chk("pop_addr", dir.pop_addr, e.addr);
        chk("pop_is_write", 32'(dir.pop_is_write), 32'(e.wr));
      end
    end
  end

  task automatic tick();
    @(posedge pclk);
    #1;
  endtask

  task automatic chk_stat(input int tag, input int exp_state);
    stat_tag = TW'(tag);
    #1;
    chk($sformatf("stat_state[%0d]", tag), 32'(stat_state), 32'(exp_state));
  endtask

  task automatic do_alloc(input logic [AW-1:0] addr, input logic wr, input int exp_tag);
    chk("alloc_rdy", 32'(dir.alloc_rdy), 32'd1);
    chk("alloc_tag", 32'(dir.alloc_tag), 32'(exp_tag));
    dir.alloc_vld = 1'b1; dir.alloc_addr = addr; dir.alloc_is_write = wr;
    dir.alloc_len = 8'd3; dir.alloc_size = 3'd2;
    tick();
    dir.alloc_vld = 1'b0;
  endtask

  task automatic do_pop(input int tag, input logic [AW-1:0] addr, input logic wr);
    pop_exp_t e;
    e.tag = TW'(tag); e.addr = addr; e.wr = wr;
    exp_q.push_back(e);
    chk("pop_vld_before_pop", 32'(dir.pop_vld), 32'd1);
    dir.pop_rdy = 1'b1;
    tick();
    dir.pop_rdy = 1'b0;
  endtask

  task automatic do_cpl(input int tag, input logic [1:0] resp, input logic [7:0] beats, input logic err);
    dir.cpl_vld = 1'b1; dir.cpl_tag = TW'(tag); dir.cpl_resp = resp;
    dir.cpl_num_beats = beats; dir.cpl_error = err;
    tick();
    dir.cpl_vld = 1'b0; dir.cpl_error = 1'b0;
  endtask

  task automatic do_cns(input int tag);
    dir.cns_vld = 1'b1; dir.cns_tag = TW'(tag);
    tick();
    dir.cns_vld = 1'b0;
  endtask

  initial begin
    dir.alloc_vld = 0; dir.alloc_addr = '0; dir.alloc_len = '0; dir.alloc_size = '0;
    dir.alloc_is_write = 0; dir.pop_rdy = 0; dir.cpl_vld = 0; dir.cpl_tag = '0;
    dir.cpl_resp = '0; dir.cpl_num_beats = '0; dir.cpl_error = 0; dir.cns_vld = 0;
    dir.cns_tag = '0; stat_tag = '0;
    repeat (3) @(posedge pclk);
    #1 preset = 1'b0;
    tick();

    // reset values
    chk("rst_cnt_free", 32'(cnt_free), 32'd4);
    chk("rst_alloc_rdy", 32'(dir.alloc_rdy), 32'd1);
    chk("rst_pop_vld", 32'(dir.pop_vld), 32'd0);
    chk("rst_cpl_rdy", 32'(dir.cpl_rdy), 32'd1);
    chk("rst_evt_stale", 32'(evt_stale_cpl), 32'd0);
    chk("rst_evt_bad", 32'(evt_bad_cns), 32'd0);
    chk_stat(0, 0);

    // fill: tags 0..3 in order, then full
    for (int i = 0; i < 4; i++) do_alloc(32'h100 + 32'(i), 1'b1, i);
    chk("full_alloc_rdy", 32'(dir.alloc_rdy), 32'd0);
    chk("full_cnt_free", 32'(cnt_free), 32'd0);
    chk_stat(2, 1);
    chk("stat_addr_tag2", stat_addr, 32'h102);

    // age order: recycled tags 0 and 2 issue after older tag 3
    do_pop(0, 32'h100, 1'b1);
    chk("cnt_wr_pend_1", 32'(cnt_wr_pend), 32'd1);
    chk_stat(0, 2);
    do_cpl(0, 2'b00, 8'd1, 1'b0);
    chk_stat(0, 3);
    do_cns(0);
    chk("cnt_free_after_cns0", 32'(cnt_free), 32'd1);
    chk_stat(0, 0);
    do_alloc(32'hA0, 1'b1, 0);
    do_pop(1, 32'h101, 1'b1);
    do_pop(2, 32'h102, 1'b1);
    do_cpl(2, 2'b00, 8'd1, 1'b0);
    do_cns(2);
    do_cpl(1, 2'b00, 8'd1, 1'b0);
    chk("alloc_tag_reuse2", 32'(dir.alloc_tag), 32'd2);
    do_alloc(32'hB0, 1'b1, 2);
    do_pop(3, 32'h103, 1'b1);
    do_pop(0, 32'hA0, 1'b1);
    do_pop(2, 32'hB0, 1'b1);
    chk("cnt_wr_pend_3", 32'(cnt_wr_pend), 32'd3);
    do_cpl(3, 2'b00, 8'd1, 1'b0);
    do_cpl(0, 2'b00, 8'd1, 1'b0);
    do_cpl(2, 2'b00, 8'd1, 1'b0);
    do_cns(1); do_cns(3); do_cns(0); do_cns(2);
    chk("cnt_free_drained", 32'(cnt_free), 32'd4);
    chk("cnt_wr_pend_0", 32'(cnt_wr_pend), 32'd0);

    // read limit 2 with a write blocked behind the third read
    do_alloc(32'h200, 1'b0, 0);
    do_alloc(32'h201, 1'b0, 1);
    do_alloc(32'h202, 1'b0, 2);
    do_alloc(32'h300, 1'b1, 3);
    do_pop(0, 32'h200, 1'b0);
    do_pop(1, 32'h201, 1'b0);
    chk("cnt_rd_pend_2", 32'(cnt_rd_pend), 32'd2);
    chk("rd_limit_pop_vld", 32'(dir.pop_vld), 32'd0);
    dir.pop_rdy = 1'b1;
    tick(); tick();
    chk("rd_limit_hold_pop_vld", 32'(dir.pop_vld), 32'd0);
    dir.pop_rdy = 1'b0;
    do_cpl(0, 2'b00, 8'd1, 1'b0);
    chk("rd_unblock_pop_vld", 32'(dir.pop_vld), 32'd1);
    do_cns(3);
    chk("bad_cns_alloc", 32'(evt_bad_cns), 32'd1);
    chk_stat(3, 1);
    do_pop(2, 32'h202, 1'b0);
    chk("bad_cns_pulse_end", 32'(evt_bad_cns), 32'd0);
    do_pop(3, 32'h300, 1'b1);
    chk("cnt_rd_pend_lim", 32'(cnt_rd_pend), 32'd2);
    chk("cnt_wr_pend_lim", 32'(cnt_wr_pend), 32'd1);

    // completion fields, stale repeat, error paths, cpl+cns same tag
    do_cpl(2, 2'b00, 8'd4, 1'b0);
    chk_stat(2, 3);
    chk("stat_beats_tag2", 32'(stat_num_beats), 32'd4);
    chk("stat_resp_tag2", 32'(stat_resp), 32'd0);
    do_cpl(2, 2'b01, 8'd7, 1'b0);
    chk("stale_repeat_cpl", 32'(evt_stale_cpl), 32'd1);
    chk_stat(2, 3);
    chk("stat_beats_kept", 32'(stat_num_beats), 32'd4);
    do_cpl(1, 2'b00, 8'd2, 1'b1);
    chk("stale_pulse_end", 32'(evt_stale_cpl), 32'd0);
    chk_stat(1, 4);
    dir.cpl_vld = 1'b1; dir.cpl_tag = 2'd3; dir.cpl_resp = 2'b11;
    dir.cpl_num_beats = 8'd1; dir.cpl_error = 1'b0;
    dir.cns_vld = 1'b1; dir.cns_tag = 2'd3;
    tick();
    dir.cpl_vld = 1'b0; dir.cns_vld = 1'b0;
    chk("cpl_cns_same_bad", 32'(evt_bad_cns), 32'd1);
    chk_stat(3, 4);
    chk("stat_resp_tag3", 32'(stat_resp), 32'd3);
    do_cns(0); do_cns(1); do_cns(2); do_cns(3);
    chk("cnt_free_after_t3", 32'(cnt_free), 32'd4);

    // timeout: completion on the expiry cycle wins; otherwise TIMEOUT at 16
    do_alloc(32'h50, 1'b1, 0);
    do_alloc(32'h51, 1'b1, 1);
    do_pop(0, 32'h50, 1'b1);
    repeat (15) tick();
    do_cpl(0, 2'b00, 8'd1, 1'b0);
    chk_stat(0, 3);
    do_pop(1, 32'h51, 1'b1);
    repeat (15) tick();
    chk_stat(1, 2);
    tick();
    chk_stat(1, 5);
    chk("timeout_resp", 32'(stat_resp), 32'd2);
    do_cpl(1, 2'b00, 8'd1, 1'b0);
    chk("stale_after_timeout", 32'(evt_stale_cpl), 32'd1);
    chk_stat(1, 5);
    do_cns(1); do_cns(0);
    chk("cnt_free_after_to", 32'(cnt_free), 32'd4);

    // reset mid-operation with 3 PENDING entries
    for (int i = 0; i < 3; i++) do_alloc(32'h60 + 32'(i), 1'b1, i);
    for (int i = 0; i < 3; i++) do_pop(i, 32'h60 + 32'(i), 1'b1);
    chk("pre_rst_wr_pend", 32'(cnt_wr_pend), 32'd3);
    preset = 1'b1;
    #1;
    chk("midrst_cnt_free", 32'(cnt_free), 32'd4);
    chk("midrst_pop_vld", 32'(dir.pop_vld), 32'd0);
    for (int i = 0; i < 4; i++) chk_stat(i, 0);
    preset = 1'b0;
    tick();
    do_cpl(0, 2'b00, 8'd1, 1'b0);
    chk("stale_after_reset", 32'(evt_stale_cpl), 32'd1);
    chk_stat(0, 0);

    tick();
    chk("pop_queue_drained", 32'(exp_q.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/apb2axi_tag_directory.md
Name: apb2axi_tag_directory

Overview:
Parametrised next-generation transaction directory for the APB-to-AXI gateway. Holds up to N_ENTRIES outstanding descriptors indexed by TAG and issues them to the AXI manager FIFO in true allocation order, not lowest-tag order. Enforces separate read and write outstanding limits and times out PENDING entries whose completion never arrives. Sits between the APB register file (alloc, status, consume) and the manager FIFO / completion queue.

Parameters:
N_ENTRIES, 8, directory depth; power of 2, at least 2
TAG_W, $clog2(N_ENTRIES), tag width
ADDR_W, 32, descriptor address width
MAX_RD_OUT, 4, maximum PENDING reads; range 1..N_ENTRIES
MAX_WR_OUT, 4, maximum PENDING writes; range 1..N_ENTRIES
TIMEOUT_CYC, 1024, PENDING timeout in cycles; 0 disables timeout
TO_W, 16, timeout counter width; must satisfy TIMEOUT_CYC < 2^TO_W

Ports:
pclk  in  1  clock
preset  in  1  reset, asynchronous, active-high
alloc_vld  in  1  new descriptor offered
alloc_addr  in  ADDR_W  descriptor address
alloc_len  in  8  AXI len
alloc_size  in  3  AXI size
alloc_is_write  in  1  1 = write
alloc_rdy  out  1  at least one EMPTY entry
alloc_tag  out  TAG_W  tag assigned on an alloc handshake (lowest EMPTY tag)
pop_vld  out  1  head of age queue issuable
pop_tag  out  TAG_W  tag being issued
pop_addr/pop_len/pop_size/pop_is_write  out  ADDR_W/8/3/1  fields of the popped entry
pop_rdy  in  1  manager FIFO accepts
cpl_vld  in  1  completion from completion queue
cpl_tag  in  TAG_W  completed tag
cpl_resp  in  2  AXI resp
cpl_num_beats  in  8  beats received
cpl_error  in  1  error flag
cpl_rdy  out  1  always 1 after reset
cns_vld  in  1  APB consumed an entry
cns_tag  in  TAG_W  consumed tag
stat_tag  in  TAG_W  status select
stat_state  out  3  0 EMPTY, 1 ALLOC, 2 PENDING, 3 DONE, 4 ERROR, 5 TIMEOUT
stat_addr/stat_len/stat_size/stat_is_write/stat_resp/stat_num_beats  out  ADDR_W/8/3/1/2/8  entry fields
cnt_free  out  TAG_W+1  EMPTY entry count
cnt_rd_pend, cnt_wr_pend  out  TAG_W+1  PENDING read / write counts
evt_stale_cpl  out  1  1-cycle pulse: completion to a non-PENDING tag
evt_bad_cns  out  1  1-cycle pulse: consume of a tag not in DONE/ERROR/TIMEOUT

Behaviour:
- Reset (async assert, sync release): all entries EMPTY with fields cleared; age queue empty; counts 0 except cnt_free=N_ENTRIES; alloc_rdy=1; pop_vld=0; cpl_rdy=1; evt_* = 0.
- All state is registered; stat_*, alloc_tag, pop_*, and counts are combinational from registers.
- Alloc: alloc_rdy=(cnt_free!=0). alloc_tag = lowest EMPTY index. On handshake: store fields, set ALLOC, push tag to age queue tail. Visible via stat the next cycle.
- Age queue: circular tag FIFO, depth N_ENTRIES, pointers TAG_W+1 bits, wraps naturally. It cannot overflow because alloc requires a free entry.
- Pop: pop_vld = queue not empty AND head-type outstanding < limit (cnt_rd_pend<MAX_RD_OUT or cnt_wr_pend<MAX_WR_OUT). Head-of-line blocking is intentional; an entry is never bypassed. On pop_vld&&pop_rdy: head entry goes ALLOC->PENDING, head is dequeued, and its timeout counter is cleared.
- Completion: if the tag is PENDING, latch resp and num_beats; the entry goes to ERROR if cpl_error or resp[1] is set, otherwise DONE. If the tag is not PENDING (including TIMEOUT), drop the completion and pulse evt_stale_cpl next cycle.
- Timeout (TIMEOUT_CYC>0): the counter increments each PENDING cycle. When it equals TIMEOUT_CYC-1 with no completion that cycle, the entry goes to TIMEOUT with resp=2'b10. A completion arriving in the same cycle wins.
- Consume: if the tag is DONE/ERROR/TIMEOUT, the entry goes to EMPTY and its fields are cleared. Otherwise no state change and evt_bad_cns pulses next cycle.
- Simultaneous events:
  - Pop, completion, and consume may all occur in the same cycle on different tags; all take effect.
  - Consume freeing tag T is not visible to alloc until the next cycle.
  - Completion and consume on the same tag in the same cycle: consume is ignored (entry not yet DONE) and evt_bad_cns pulses.
- Counts are updated registered, in the same edge as the state changes.
- Reset asserted mid-operation: immediate return to reset values; in-flight completions after release are treated as stale.

Test Plan:
1. N_ENTRIES=4: alloc 4 writes -> alloc_tag 0,1,2,3; alloc_rdy=0 after the 4th; cnt_free=0.
2. Fill tags 0..3, pop tag 0, complete it, consume tag 0, free tag 2 the same way, then alloc A (gets tag 0) and B (gets tag 2). Pop order must be 1,3,0,2, i.e. age order, not tag order.
3. MAX_RD_OUT=2 with 3 reads allocated and pop_rdy=1 -> 2 pops, then pop_vld=0 while a write behind them stays blocked. Complete one read -> pop_vld=1 next cycle.
4. TIMEOUT_CYC=16: pop tag 1 and send no completion -> stat_state=5 and resp=2 after 16 cycles. A later cpl on tag 1 -> evt_stale_cpl=1 and state stays 5.
5. cpl tag 2 with resp=0 and num_beats=4 -> DONE, beats 4. A second cpl on the same tag -> evt_stale_cpl. cns on tag 3 while it is ALLOC -> evt_bad_cns and no change.
6. Assert preset while 3 entries are PENDING -> cnt_free=N_ENTRIES, pop_vld=0, all stat_state=0 immediately, before the next clock edge.
